// File: rtl/seq_addsub16_if.sv
// seq_addsub16_if: request/response bundle for the sequential add/subtract unit.
//
// Request side : in_valid, in_ready, a, b, sub
// Response side: out_valid, out_ready, sum, cout, ovf, zero
//
// modport slave  - the arithmetic unit
// modport master - the producer/consumer driving it
interface seq_addsub16_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );
endinterface

// File: rtl/seq_addsub16.sv
// seq_addsub16: multi-cycle a +/- b, one 4-bit carry-lookahead group per clock,
// least-significant group first. The group carry-out lives in a register between cycles.
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - seq_addsub16_if.slave: in_valid/in_ready/a/b/sub request,
//           out_valid/out_ready/sum/cout/ovf/zero response
//
// Optional feature: define SEQ_ADDSUB16_FLAGS_EN to build the signed-overflow (ovf)
// and zero-detect (zero) flags; without it both outputs are tied to 0.
module seq_addsub16 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    seq_addsub16_if.slave  bus
);
    localparam int unsigned NG = WIDTH / 4;
    localparam int unsigned GW = (NG > 1) ? $clog2(NG) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [GW-1:0]    grp_q, grp_d;

    // Current group slice and its lookahead terms
    logic [3:0] na, nb, g, p, c, nsum;
    logic       gout, pout, cnext, last_grp;

    always_comb begin
        na   = opa_q[{grp_q, 2'b00} +: 4];
        nb   = opb_q[{grp_q, 2'b00} +: 4];
        g    = na & nb;
        p    = na | nb;
        c[0] = carry_q;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        gout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        pout = &p;
        cnext = gout | (pout & carry_q);
        nsum = na ^ nb ^ c;
        last_grp = (grp_q == GW'(NG - 1));
    end

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        grp_d   = grp_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    opa_d   = bus.a;
                    // Subtract as a + ~b + 1: the +1 enters as the initial carry
                    opb_d   = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub;
                    grp_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    state_d = StRun;
                end
            end
            StRun: begin
                sum_d[{grp_q, 2'b00} +: 4] = nsum;
                carry_d = cnext;
                grp_d   = grp_q + 1'b1;
                if (last_grp) begin
                    cout_d  = cnext;
                    grp_d   = '0;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            opa_q   <= '0;
            opb_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            grp_q   <= '0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            grp_q   <= grp_d;
        end
    end

    // Handshake outputs decode the state register only
    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;

`ifdef SEQ_ADDSUB16_FLAGS_EN
    logic ovf_q, ovf_d;
    logic zero_q, zero_d;

    always_comb begin
        ovf_d  = ovf_q;
        zero_d = zero_q;
        if (state_q == StIdle && bus.in_valid) begin
            ovf_d  = 1'b0;
            zero_d = 1'b0;
        end else if (state_q == StRun && last_grp) begin
            // c[3] is the carry into the MSB of the final group
            ovf_d  = c[3] ^ cnext;
            zero_d = (sum_d == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign bus.ovf  = ovf_q;
    assign bus.zero = zero_q;
`else
    assign bus.ovf  = 1'b0;
    assign bus.zero = 1'b0;
`endif

endmodule

// File: tb/tb_seq_addsub16.sv
// Bench for seq_addsub16 (WIDTH=16): directed vectors with literal expectations plus a
// cycle-by-cycle compare against an arithmetic model of the request/response stream.
module tb_seq_addsub16;
    localparam int unsigned WIDTH = 16;
    localparam int unsigned NG    = WIDTH / 4;

`ifdef SEQ_ADDSUB16_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic clk;
    logic rst_n;

    seq_addsub16_if #(.WIDTH(WIDTH)) bus ();

    seq_addsub16 #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    // Plain arithmetic: unsigned result/carry, signed range test for overflow
    function automatic res_t model(input logic [15:0] a, input logic [15:0] b, input logic sub);
        res_t r;
        int   sa, sb, sr;
        int   ua, ub;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sub) begin
            r.sum  = 16'(ua - ub);
            r.cout = (ua >= ub);
            sr     = sa - sb;
        end else begin
            r.sum  = 16'(ua + ub);
            r.cout = (ua + ub) > 65535;
            sr     = sa + sb;
        end
        r.ovf  = FLAGS && (sr > 32767 || sr < -32768);
        r.zero = FLAGS && (r.sum == 16'h0000);
        return r;
    endfunction

    // Compare process: model queue fed at acceptance, checked every cycle
    res_t exp_q[$];
    int   lat;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            lat = 0;
        end else begin
            if (exp_q.size() > 0) lat++;
            chk("mon_in_ready", 32'(bus.in_ready), 32'(exp_q.size() == 0));
            chk("mon_out_valid", 32'(bus.out_valid), 32'(exp_q.size() > 0 && lat > NG));
            if (bus.out_valid && exp_q.size() > 0) begin
                chk("mon_sum", 32'(bus.sum), 32'(exp_q[0].sum));
                chk("mon_cout", 32'(bus.cout), 32'(exp_q[0].cout));
                chk("mon_ovf", 32'(bus.ovf), 32'(exp_q[0].ovf));
                chk("mon_zero", 32'(bus.zero), 32'(exp_q[0].zero));
                if (bus.out_ready) void'(exp_q.pop_front());
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(bus.a, bus.b, bus.sub));
                lat = 0;
            end
        end
    end

    // Directed driving; all tasks start and end at posedge+1
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic sub);
        int n;
        bus.a = a; bus.b = b; bus.sub = sub; bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("send_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.a = $urandom; bus.b = $urandom; bus.sub = $urandom_range(0, 1);
    endtask

    task automatic wait_result(input string name);
        int n;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk({name, "_latency"}, 32'(n), 32'd4);
    endtask

    task automatic expect_out(input string name, input logic [15:0] s, input logic co,
                              input logic ov, input logic zr);
        chk({name, "_sum"}, 32'(bus.sum), 32'(s));
        chk({name, "_cout"}, 32'(bus.cout), 32'(co));
        chk({name, "_ovf"}, 32'(bus.ovf), 32'(ov && FLAGS));
        chk({name, "_zero"}, 32'(bus.zero), 32'(zr && FLAGS));
    endtask

    task automatic take(input string name);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk({name, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
        chk({name, "_ready_back"}, 32'(bus.in_ready), 32'd1);
    endtask

    task automatic op(input string name, input logic [15:0] a, input logic [15:0] b,
                      input logic sub, input logic [15:0] s, input logic co,
                      input logic ov, input logic zr);
        send(a, b, sub);
        wait_result(name);
        expect_out(name, s, co, ov, zr);
        take(name);
    endtask

    res_t m;

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.a = '0; bus.b = '0; bus.sub = 1'b0;

        // Pin the model against hand arithmetic
        m = model(16'h1234, 16'h4321, 1'b0);
        chk("model_add_sum", 32'(m.sum), 32'h5555);
        m = model(16'h8000, 16'h0001, 1'b1);
        chk("model_sub_sum", 32'(m.sum), 32'h7FFF);
        chk("model_sub_cout", 32'(m.cout), 32'd1);
        chk("model_sub_ovf", 32'(m.ovf), 32'(FLAGS));

        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_sum", 32'(bus.sum), 32'd0);
        chk("rst_cout", 32'(bus.cout), 32'd0);

        op("add1", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
        op("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        op("sub_ovf", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        op("sub_eq", 16'hA5A5, 16'hA5A5, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        op("add_mix", 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);

        // Backpressure in DONE with a competing request
        send(16'h1111, 16'h2222, 1'b0);
        wait_result("bp");
        expect_out("bp", 16'h3333, 1'b0, 1'b0, 1'b0);
        bus.a = 16'h0003; bus.b = 16'h0004; bus.sub = 1'b0; bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_hold_sum", 32'(bus.sum), 32'h3333);
            chk("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        take("bp");
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("bp_new_taken", 32'(bus.in_ready), 32'd0);
        wait_result("bp2");
        expect_out("bp2", 16'h0007, 1'b0, 1'b0, 1'b0);
        take("bp2");

        // Asynchronous reset after two groups
        send(16'h1234, 16'h1111, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_sum", 32'(bus.sum), 32'd0);
        chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("arst_cout", 32'(bus.cout), 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        op("post_rst", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seq_addsub16.md
# seq_addsub16

Multi-cycle add/subtract unit that computes a ± b over WIDTH bits by evaluating one 4-bit carry-lookahead group per clock, least-significant group first. Each group uses generate/propagate logic equivalent to the team's 4-bit CLA slice, and the group carry-out is held in a register between cycles. The block is the sequential, handshaked consumer of the CLA slice, used where area matters more than latency. Operands enter through a valid/ready request port, and results leave through a valid/ready response port.

## Interface
- WIDTH, 16: operand and result width. Must be a multiple of 4 and at least 4. NG = WIDTH/4 groups.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- a  in  WIDTH  first operand (unsigned or two's complement).
- b  in  WIDTH  second operand.
- sub  in  1  0 computes a+b; 1 computes a−b.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  final carry. For subtraction, 1 means no borrow (a ≥ b unsigned).
- ovf  out  1  signed overflow (see Configuration).
- zero  out  1  sum == 0 (see Configuration).

## Operation
- The FSM has three states: IDLE, RUN, DONE. Reset state is IDLE.
- In IDLE:
  - in_ready=1.
  - When in_valid=1, the block latches a into opa and sub ? ~b : b into opb.
  - It sets the carry register to sub, clears grp to 0, clears sum, and moves to RUN.
- In RUN:
  - For group k=grp, g[i]=opa[i]&opb[i] and p[i]=opa[i]|opb[i] for the 4 bits.
  - Carries ripple through the lookahead equations from the carry register.
  - sum[4k+3:4k] = opa^opb^c for that nibble.
  - The carry register takes gout | (pout & carry).
  - grp increments. When grp==NG−1, the next state is DONE.
- In the last group, the block also records the carry into the MSB, which is needed for ovf.
- In DONE:
  - out_valid=1, and sum, cout, ovf and zero are held stable.
  - When out_ready=1, the next state is IDLE.
- in_ready=0 in both RUN and DONE. in_valid is ignored outside IDLE.
- Input ports a, b and sub may change freely after acceptance.
- Reset in any state (asynchronous):
  - State returns to IDLE and grp to 0.
  - sum=0, cout=0, ovf=0, zero=0, out_valid=0, in_ready=1.
  - Any in-flight operation is discarded. No partial result is emitted.

## Timing
- Acceptance happens at the edge E0 where in_valid & in_ready.
- Group k is written at edge E(k+1). out_valid rises at edge E(NG), which is 4 cycles for WIDTH=16.
- sum nibbles update progressively during RUN. Only the values in DONE are defined.
- Output handshake completes at the edge where out_valid & out_ready. out_valid is low in the following cycle.
- in_ready rises in the cycle after the output handshake.
- Minimum spacing between accepts is NG+2 cycles.
- No combinational path exists from in_valid or out_ready to any output. in_ready and out_valid are decoded from the state register only.

## Configuration
- Macro: SEQ_ADDSUB16_FLAGS_EN.
- Defined:
  - ovf = carry_into_msb ^ cout, registered with the last group.
  - zero = (sum == 0), registered at entry to DONE.
- Undefined:
  - ovf and zero are tied to constant 0.
  - The MSB-carry and zero-detect logic are not present.
- sum, cout and the handshake behave identically in both builds.

## Test plan
1. Add 0x1234 + 0x4321: sum=0x5555, cout=0, ovf=0, zero=0. out_valid rises exactly 4 cycles after acceptance.
2. Add 0xFFFF + 0x0001: sum=0x0000, cout=1, zero=1, ovf=0. Checks the carry rippling through all four groups.
3. Sub 0x0005 − 0x0007: sum=0xFFFE, cout=0 (borrow), ovf=0.
4. Overflow cases (flags build):
   - Sub 0x8000 − 0x0001 gives sum=0x7FFF, cout=1, ovf=1.
   - Add 0x7FFF + 0x0001 gives 0x8000, ovf=1.
   - Without the macro, both report ovf=0 and zero=0 with the same sum and cout.
5. Backpressure:
   - Hold out_ready=0 for 3 cycles in DONE: out_valid stays 1 and sum stays stable.
   - Assert in_valid with a new request meanwhile: in_ready=0 and the request is not taken.
   - Release out_ready: in_ready=1 on the next cycle, and the new request is accepted.
6. Reset after 2 groups of an add:
   - Immediately (asynchronously): out_valid=0, sum=0, in_ready=1.
   - After release: a fresh 0x0001+0x0001 returns 0x0002 four cycles after acceptance.
